// File: rtl/morse_pkg.sv
// Shared constants and the ITU Morse lookup for the character decoder.
// The lookup result is {hit, ascii}; ascii is '?' when hit is 0.
package morse_pkg;

    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_ERR   = 8'h3F;

    localparam logic [1:0] STATUS_IDLE = 2'b00;
    localparam logic [1:0] STATUS_RECV = 2'b01;
    localparam logic [1:0] STATUS_GAP  = 2'b10;
    localparam logic [1:0] STATUS_ERR  = 2'b11;

    localparam logic [1:0] ELEM_NONE = 2'b00;
    localparam logic [1:0] ELEM_DOT  = 2'b01;
    localparam logic [1:0] ELEM_DASH = 2'b10;

    // Only the low len bits of the shift register are meaningful; first element at the MSB, 1 = dash.
    function automatic logic [8:0] morse_lookup(input logic [2:0] len, input logic [5:0] bits);
        logic [5:0] mask;
        logic [8:0] res;
        mask = 6'((7'd1 << len) - 7'd1);
        res  = {1'b0, ASCII_ERR};
        case ({len, bits & mask})
            {3'd2, 6'b000001}: res = {1'b1, 8'h41}; // A .-
            {3'd4, 6'b001000}: res = {1'b1, 8'h42}; // B -...
            {3'd4, 6'b001010}: res = {1'b1, 8'h43}; // C -.-.
            {3'd3, 6'b000100}: res = {1'b1, 8'h44}; // D -..
            {3'd1, 6'b000000}: res = {1'b1, 8'h45}; // E .
            {3'd4, 6'b000010}: res = {1'b1, 8'h46}; // F ..-.
            {3'd3, 6'b000110}: res = {1'b1, 8'h47}; // G --.
            {3'd4, 6'b000000}: res = {1'b1, 8'h48}; // H ....
            {3'd2, 6'b000000}: res = {1'b1, 8'h49}; // I ..
            {3'd4, 6'b000111}: res = {1'b1, 8'h4A}; // J .---
            {3'd3, 6'b000101}: res = {1'b1, 8'h4B}; // K -.-
            {3'd4, 6'b000100}: res = {1'b1, 8'h4C}; // L .-..
            {3'd2, 6'b000011}: res = {1'b1, 8'h4D}; // M --
            {3'd2, 6'b000010}: res = {1'b1, 8'h4E}; // N -.
            {3'd3, 6'b000111}: res = {1'b1, 8'h4F}; // O ---
            {3'd4, 6'b000110}: res = {1'b1, 8'h50}; // P .--.
            {3'd4, 6'b001101}: res = {1'b1, 8'h51}; // Q --.-
            {3'd3, 6'b000010}: res = {1'b1, 8'h52}; // R .-.
            {3'd3, 6'b000000}: res = {1'b1, 8'h53}; // S ...
            {3'd1, 6'b000001}: res = {1'b1, 8'h54}; // T -
            {3'd3, 6'b000001}: res = {1'b1, 8'h55}; // U ..-
            {3'd4, 6'b000001}: res = {1'b1, 8'h56}; // V ...-
            {3'd3, 6'b000011}: res = {1'b1, 8'h57}; // W .--
            {3'd4, 6'b001001}: res = {1'b1, 8'h58}; // X -..-
            {3'd4, 6'b001011}: res = {1'b1, 8'h59}; // Y -.--
            {3'd4, 6'b001100}: res = {1'b1, 8'h5A}; // Z --..
            {3'd5, 6'b011111}: res = {1'b1, 8'h30};
            {3'd5, 6'b001111}: res = {1'b1, 8'h31};
            {3'd5, 6'b000111}: res = {1'b1, 8'h32};
            {3'd5, 6'b000011}: res = {1'b1, 8'h33};
            {3'd5, 6'b000001}: res = {1'b1, 8'h34};
            {3'd5, 6'b000000}: res = {1'b1, 8'h35};
            {3'd5, 6'b010000}: res = {1'b1, 8'h36};
            {3'd5, 6'b011000}: res = {1'b1, 8'h37};
            {3'd5, 6'b011100}: res = {1'b1, 8'h38};
            {3'd5, 6'b011110}: res = {1'b1, 8'h39};
            default:           res = {1'b0, ASCII_ERR};
        endcase
        return res;
    endfunction

endpackage

// File: rtl/morse_debounce.sv
// Key debouncer: one synchroniser flop feeding a saturating up/down counter.
// Q only moves once the counter has sat at a rail, so latency is 2^DEB_BITS+1 clocks.
module morse_debounce #(
    parameter int DEB_BITS = 16
) (
    input  logic C,
    input  logic nR,
    input  logic aX,
    output logic Q
);

    logic                syncQ;
    logic [DEB_BITS-1:0] cnt;

    always_ff @(posedge C or negedge nR) begin
        if (!nR) begin
            syncQ <= 1'b0;
            cnt   <= '0;
            Q     <= 1'b0;
        end else begin
            syncQ <= aX;
            if (syncQ && (cnt != '1)) begin
                cnt <= cnt + DEB_BITS'(1);
            end else if (!syncQ && (cnt != '0)) begin
                cnt <= cnt - DEB_BITS'(1);
            end
            if (cnt == '1) begin
                Q <= 1'b1;
            end else if (cnt == '0) begin
                Q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/morse_char_decoder.sv
// Morse receiver: debounced key -> unit-timed mark/space classification -> one ASCII code per character.
// ValidY is a one-clock strobe with no backpressure; CharY/ErrY are updated with it and held until the next strobe.
module morse_char_decoder
    import morse_pkg::*;
#(
    parameter int CLK_PER_UNIT = 12_500_000,
    parameter int DEB_BITS     = 16,
    parameter int DASH_MIN     = 2,
    parameter int CHAR_GAP     = 3,
    parameter int WORD_GAP     = 7,
    parameter int MAX_ELEM     = 6
) (
    input  logic       C,
    input  logic       nR,
    input  logic       aM,
    output logic [7:0] CharY,
    output logic       ValidY,
    output logic       ErrY,
    output logic [1:0] ElemY,
    output logic [1:0] StatusY
);

    localparam int PW = $clog2(CLK_PER_UNIT);
    localparam int SW = $clog2(WORD_GAP + 1);
    localparam int MW = $clog2(DASH_MIN + 1);

    localparam logic [PW-1:0] PRE_LAST  = PW'(CLK_PER_UNIT - 1);
    localparam logic [MW-1:0] DASH_TOP  = MW'(DASH_MIN);
    localparam logic [SW-1:0] CHAR_PREV = SW'(CHAR_GAP - 1);
    localparam logic [SW-1:0] WORD_PREV = SW'(WORD_GAP - 1);
    localparam logic [SW-1:0] WORD_TOP  = SW'(WORD_GAP);
    localparam logic [2:0]    LEN_MAX   = 3'(MAX_ELEM);

    logic          keyQ;
    logic          keyQd;
    logic          riseY;
    logic          fallY;
    logic          tick;
    logic [PW-1:0] preCnt;
    logic [MW-1:0] markCnt;
    logic [SW-1:0] spaceCnt;
    logic [5:0]    sh;
    logic [2:0]    len;
    logic          ovf;
    logic          wordPend;
    logic          charEnd;
    logic          wordEnd;
    logic [8:0]    lookupRes;

    morse_debounce #(
        .DEB_BITS(DEB_BITS)
    ) u_debounce (
        .C  (C),
        .nR (nR),
        .aX (aM),
        .Q  (keyQ)
    );

    assign riseY = keyQ & ~keyQd;
    assign fallY = ~keyQ & keyQd;

    // A key edge re-phases the unit timer, so a terminal count on the edge cycle is dropped.
    assign tick = (preCnt == PRE_LAST) && !riseY && !fallY;

    assign charEnd = tick && !keyQ && (spaceCnt == CHAR_PREV) && (len != 3'd0);
    assign wordEnd = tick && !keyQ && (spaceCnt == WORD_PREV) && wordPend;

    assign lookupRes = morse_lookup(len, sh);

    always_ff @(posedge C or negedge nR) begin
        if (!nR) begin
            keyQd  <= 1'b0;
            preCnt <= '0;
        end else begin
            keyQd <= keyQ;
            if (riseY || fallY || (preCnt == PRE_LAST)) begin
                preCnt <= '0;
            end else begin
                preCnt <= preCnt + PW'(1);
            end
        end
    end

    always_ff @(posedge C or negedge nR) begin
        if (!nR) begin
            markCnt  <= '0;
            spaceCnt <= '0;
        end else if (riseY) begin
            markCnt  <= '0;
            spaceCnt <= '0;
        end else if (tick) begin
            if (keyQ && (markCnt != DASH_TOP)) begin
                markCnt <= markCnt + MW'(1);
            end
            if (!keyQ && (spaceCnt != WORD_TOP)) begin
                spaceCnt <= spaceCnt + SW'(1);
            end
        end
    end

    // Element capture and character/word emission share len/ovf, so they live together.
    always_ff @(posedge C or negedge nR) begin
        if (!nR) begin
            sh       <= '0;
            len      <= '0;
            ovf      <= 1'b0;
            wordPend <= 1'b0;
            CharY    <= 8'h00;
            ValidY   <= 1'b0;
            ErrY     <= 1'b0;
        end else begin
            ValidY <= 1'b0;
            if (fallY) begin
                if (len == LEN_MAX) begin
                    ovf <= 1'b1;
                end else begin
                    sh  <= {sh[4:0], markCnt == DASH_TOP};
                    len <= len + 3'd1;
                end
            end
            if (charEnd) begin
                ValidY   <= 1'b1;
                CharY    <= lookupRes[8] ? lookupRes[7:0] : ASCII_ERR;
                ErrY     <= !lookupRes[8] || ovf;
                sh       <= '0;
                len      <= '0;
                ovf      <= 1'b0;
                wordPend <= 1'b1;
            end else if (wordEnd) begin
                ValidY   <= 1'b1;
                CharY    <= ASCII_SPACE;
                ErrY     <= 1'b0;
                wordPend <= 1'b0;
            end
        end
    end

    // On the rise cycle markCnt still holds the previous mark, so report a fresh dot there.
    always_comb begin
        ElemY = ELEM_NONE;
        if (keyQ) begin
            ElemY = (!riseY && (markCnt == DASH_TOP)) ? ELEM_DASH : ELEM_DOT;
        end
    end

    always_comb begin
        StatusY = STATUS_IDLE;
        if (ErrY) begin
            StatusY = STATUS_ERR;
        end else if ((len != 3'd0) || keyQ) begin
            StatusY = STATUS_RECV;
        end else if (wordPend) begin
            StatusY = STATUS_GAP;
        end
    end

endmodule

// File: tb/tb_morse_char_decoder.sv
// Directed bench for morse_char_decoder with a scoreboard of expected {ErrY, CharY} emissions.
module tb_morse_char_decoder;

    localparam int U    = 4;
    localparam int CGAP = 3 * U + 2;

    logic       C;
    logic       nR;
    logic       aM;
    logic [7:0] CharY;
    logic       ValidY;
    logic       ErrY;
    logic [1:0] ElemY;
    logic [1:0] StatusY;

    int         testCnt = 0;
    int         failCnt = 0;
    logic [8:0] exp_q[$];
    logic [8:0] monWant;

    morse_char_decoder #(
        .CLK_PER_UNIT(U),
        .DEB_BITS    (2)
    ) dut (
        .C       (C),
        .nR      (nR),
        .aM      (aM),
        .CharY   (CharY),
        .ValidY  (ValidY),
        .ErrY    (ErrY),
        .ElemY   (ElemY),
        .StatusY (StatusY)
    );

    initial C = 1'b0;
    always #5 C = ~C;

    task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        testCnt++;
        assert (obs === exp) else begin
            failCnt++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge C);
    endtask

    task automatic mark(input int n);
        aM = 1'b1;
        repeat (n) @(negedge C);
        aM = 1'b0;
    endtask

    task automatic sendPattern(input string p);
        byte ch;
        for (int i = 0; i < p.len(); i++) begin
            ch = p[i];
            mark((ch == 8'h2D) ? 3 * U : U);
            if (i != p.len() - 1) idle(U);
        end
    endtask

    // Scoreboard: every strobe must match the oldest expected emission.
    always @(negedge C) begin
        if (nR && ValidY) begin
            testCnt++;
            assert (exp_q.size() != 0) else begin
                failCnt++;
                $error("FAIL unexpected_valid: got %h expected no strobe", {ErrY, CharY});
            end
            if (exp_q.size() != 0) begin
                monWant = exp_q.pop_front();
                check("emission", {ErrY, CharY}, monWant);
            end
        end
    end

    initial begin
        aM = 1'b0;
        nR = 1'b0;
        idle(3);
        nR = 1'b1;
        check("reset_char", {1'b0, CharY}, 9'h000);
        check("reset_valid_err", {7'b0, ValidY, ErrY}, 9'h000);
        check("reset_elem", {7'b0, ElemY}, 9'h000);
        check("reset_status", {7'b0, StatusY}, 9'h000);
        idle(100);
        check("idle_status", {7'b0, StatusY}, 9'h000);
        check("idle_char", {1'b0, CharY}, 9'h000);

        // 'A' then a long space
        exp_q.push_back({1'b0, 8'h41});
        exp_q.push_back({1'b0, 8'h20});
        mark(U);
        idle(2);
        check("dot_elem", {7'b0, ElemY}, 9'h001);
        check("recv_status", {7'b0, StatusY}, 9'h001);
        idle(2);
        mark(3 * U);
        idle(3);
        check("dash_elem", {7'b0, ElemY}, 9'h002);
        idle(17);
        check("a_emitted", 9'(exp_q.size()), 9'd1);
        check("between_status", {7'b0, StatusY}, 9'h002);
        check("a_char", {ErrY, CharY}, {1'b0, 8'h41});
        idle(40);
        check("a_word_done", 9'(exp_q.size()), 9'd0);
        check("idle_after_word", {7'b0, StatusY}, 9'h000);

        // "01 " and no repeated space
        exp_q.push_back({1'b0, 8'h30});
        exp_q.push_back({1'b0, 8'h31});
        exp_q.push_back({1'b0, 8'h20});
        sendPattern("-----");
        idle(CGAP);
        sendPattern(".----");
        idle(40);
        check("digits_done", 9'(exp_q.size()), 9'd0);
        idle(40);
        check("single_space_char", {ErrY, CharY}, {1'b0, 8'h20});

        // six dots (no such code) then seven dots (overflow)
        exp_q.push_back({1'b1, 8'h3F});
        sendPattern("......");
        idle(20);
        check("six_dot_err", {ErrY, CharY}, {1'b1, 8'h3F});
        check("six_dot_status", {7'b0, StatusY}, 9'h003);
        exp_q.push_back({1'b1, 8'h3F});
        sendPattern(".......");
        idle(20);
        check("ovf_done", 9'(exp_q.size()), 9'd0);
        check("ovf_status", {7'b0, StatusY}, 9'h003);
        exp_q.push_back({1'b0, 8'h20});
        idle(30);
        check("err_cleared_status", {7'b0, StatusY}, 9'h000);

        // 'N' with a short key bounce inside the following space
        exp_q.push_back({1'b0, 8'h4E});
        exp_q.push_back({1'b0, 8'h20});
        sendPattern("-.");
        idle(8);
        aM = 1'b1;
        idle(2);
        aM = 1'b0;
        idle(2);
        check("glitch_elem", {7'b0, ElemY}, 9'h000);
        check("glitch_status", {7'b0, StatusY}, 9'h001);
        idle(10);
        check("glitch_emitted", 9'(exp_q.size()), 9'd1);
        idle(40);
        check("glitch_done", 9'(exp_q.size()), 9'd0);

        // reset mid-gap discards "-.", then 'S'
        sendPattern("-.");
        idle(8);
        nR = 1'b0;
        idle(2);
        nR = 1'b1;
        check("midreset_char", {1'b0, CharY}, 9'h000);
        check("midreset_status", {7'b0, StatusY}, 9'h000);
        idle(40);
        exp_q.push_back({1'b0, 8'h53});
        exp_q.push_back({1'b0, 8'h20});
        sendPattern("...");
        idle(20);
        check("s_emitted", 9'(exp_q.size()), 9'd1);
        idle(40);
        check("drain", 9'(exp_q.size()), 9'd0);

        $display("[TB] %0d tests run, %0d failed", testCnt, failCnt);
        $finish;
    end

endmodule
